mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the CPU's single-port synchronous instruction/data RAM between the fetch stage and the load/store unit. Sits between the pipeline and the 1024-word program memory. Grants one access per cycle and routes each read return to its owner one cycle later. Enforces data-over-fetch priority, with an optional starvation guard and a saturating conflict counter for performance debug.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between instruction fetch and the load/store unit.
//   Grants one access per cycle (data wins by default), drives the RAM bus from the winner,
//   and returns read data to the owning port one cycle after the grant.
//   Ports: clk, rst (async, active-high)
//          fetch: if_req, if_addr -> if_gnt (comb), if_rvalid (reg), if_rdata
//          data : d_req, d_we, d_addr, d_wdata, d_wstrb -> d_gnt (comb), d_rvalid (reg), d_rdata
//          RAM  : mem_en, mem_we, mem_be, mem_addr, mem_wdata, mem_rdata
//          debug: conflict_cnt (saturating count of cycles with both requests high)
//   Build option: ARB_STARVE_GUARD_EN forces a fetch grant after MAX_WAIT consecutive denials.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;
  owner_e owner_q, owner_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d, d_hold_q, d_hold_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic fetch_force;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;
  assign fetch_force = wait_q == 4'(MAX_WAIT);
  always_comb wait_d = (if_req & ~if_gnt) ? wait_q + 4'd1 : 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_q <= 4'd0;
    else     wait_q <= wait_d;
`else
  // MAX_WAIT only matters in the guard build; the comparison is constant false
  assign fetch_force = MAX_WAIT < 0;
`endif
  always_comb begin
    if_gnt    = ~rst & if_req & (~d_req | fetch_force);
    d_gnt     = ~rst & d_req & ~if_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = if_gnt ? '1 : d_gnt ? (d_we ? d_wstrb : '1) : '0;
    mem_addr  = if_gnt ? if_addr : d_addr;
    mem_wdata = d_wdata;
    owner_d   = if_gnt ? OWN_FETCH : (d_gnt & ~d_we) ? OWN_DATA : OWN_NONE;
    if_rvalid = owner_q == OWN_FETCH;
    d_rvalid  = owner_q == OWN_DATA;
    if_hold_d = if_rvalid ? mem_rdata : if_hold_q;
    d_hold_d  = d_rvalid ? mem_rdata : d_hold_q;
    if_rdata  = if_hold_d;
    d_rdata   = d_hold_d;
    conflict_d = (if_req & d_req & ~&conflict_q) ? conflict_q + 1'b1 : conflict_q;
    conflict_cnt = conflict_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner_q    <= OWN_NONE;
      if_hold_q  <= '0;
      d_hold_q   <= '0;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      if_hold_q  <= if_hold_d;
      d_hold_q   <= d_hold_d;
      conflict_q <= conflict_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a behavioural sync RAM.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [9:0] if_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic [3:0] d_wstrb = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_be, conflict_cnt;
  logic [9:0] mem_addr;
  logic [31:0] ram [0:1023];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt));
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else mem_rdata <= ram[mem_addr];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[3] = 32'h00000013;
    ram[5] = 32'h00a00413;
    ram[6] = 32'h00600593;
    ram[7] = 32'h11223344;
    mem_rdata = 32'h0;
    if_req = 1;
    #2;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_conflict", conflict_cnt, 0);
    if_req = 0;
    @(negedge clk); rst = 0;
    @(negedge clk); if_req = 1; if_addr = 3;
    #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_be", mem_be, 4'hF);
    chk("f_mem_addr", mem_addr, 3);
    @(posedge clk); #1;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h00000013);
    chk("f_d_rvalid", d_rvalid, 0);
    @(negedge clk); if_req = 0;
    #1;
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_be", mem_be, 0);
    @(posedge clk); #1;
    chk("f_rvalid_drop", if_rvalid, 0);
    chk("f_rdata_hold", if_rdata, 32'h00000013);
    @(negedge clk); if_req = 1; if_addr = 6; d_req = 1; d_we = 0; d_addr = 5;
    #1;
    chk("c_d_gnt", d_gnt, 1);
    chk("c_if_gnt", if_gnt, 0);
    chk("c_mem_addr", mem_addr, 5);
    @(posedge clk); #1;
    chk("c_d_rvalid", d_rvalid, 1);
    chk("c_d_rdata", d_rdata, 32'h00a00413);
    chk("c_if_rvalid0", if_rvalid, 0);
    chk("c_conflict", conflict_cnt, 1);
    @(negedge clk); d_req = 0;
    #1;
    chk("c_if_gnt_retry", if_gnt, 1);
    chk("c_mem_addr2", mem_addr, 6);
    @(posedge clk); #1;
    chk("c_if_rvalid", if_rvalid, 1);
    chk("c_if_rdata", if_rdata, 32'h00600593);
    chk("c_d_rvalid0", d_rvalid, 0);
    chk("c_d_rdata_hold", d_rdata, 32'h00a00413);
    chk("c_conflict_keep", conflict_cnt, 1);
    @(negedge clk); if_req = 0; d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    #1;
    chk("s_d_gnt", d_gnt, 1);
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_be", mem_be, 4'b0011);
    chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("s_no_d_rvalid", d_rvalid, 0);
    chk("s_no_if_rvalid", if_rvalid, 0);
    @(negedge clk); d_we = 0;
    #1;
    chk("l_mem_be", mem_be, 4'hF);
    @(posedge clk); #1;
    chk("l_d_rvalid", d_rvalid, 1);
    chk("l_d_rdata_merge", d_rdata, 32'h1122BEEF);
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 5; if_req = 1; if_addr = 3;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("sv_if_gnt_%0d", k), if_gnt, k == 4);
      chk($sformatf("sv_d_gnt_%0d", k), d_gnt, k != 4);
    end
    @(negedge clk); #1;
    chk("sv_conflict", conflict_cnt, 6);
    chk("sv_d_wins_again", d_gnt, 1);
`else
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("sv_if_gnt_%0d", k), if_gnt, 0);
    end
    @(negedge clk); #1;
    chk("sv_conflict", conflict_cnt, 4'hF);
`endif
    for (int k = 0; k < 19; k++) @(negedge clk);
    #1;
    chk("sat_conflict", conflict_cnt, 4'hF);
    @(negedge clk); #1;
    chk("sat_conflict_hold", conflict_cnt, 4'hF);
    d_req = 0; if_req = 1; if_addr = 3;
    #1;
    chk("r_if_gnt", if_gnt, 1);
    @(posedge clk); #1;
    chk("r_if_rvalid", if_rvalid, 1);
    #1 rst = 1;
    #1;
    chk("r_if_rvalid_async", if_rvalid, 0);
    chk("r_if_rdata_async", if_rdata, 0);
    chk("r_conflict_async", conflict_cnt, 0);
    chk("r_if_gnt_forced", if_gnt, 0);
    chk("r_mem_en_forced", mem_en, 0);
    if_req = 0;
    #1 rst = 0;
    @(posedge clk); #1;
    chk("r_no_rvalid_after", if_rvalid, 0);
    chk("r_no_d_rvalid_after", d_rvalid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
